// File: rtl/prga.sv
// ---------------------------------------------------------------------------
// prga -- RC4 pseudo-random generation + decrypt engine.
//
// Reads a message from the ciphertext memory (ct[0] = length L, ct[1..L] =
// bytes), steps the RC4 PRGA over an S memory that key scheduling has already
// filled, and writes pt[0] = L, pt[k] = ct[k] ^ pad_k to the plaintext memory.
// All memories are synchronous-read with one wait state. An address registered
// on the edge that enters a RD_* state is sampled by the memory at the end of
// that state. Its data is captured on the edge that leaves the following WT_*
// state.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   en / rdy            start request / idle and able to accept en
//   s_addr, s_rddata,   S memory port (256x8, read/write)
//   s_wrdata, s_wren
//   ct_addr, ct_rddata  ciphertext memory read port
//   pt_addr, pt_wrdata, plaintext memory write port
//   pt_wren
// ---------------------------------------------------------------------------
module prga (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);

    typedef enum logic [3:0] {
        IDLE, LEN_RD, LEN_WT, LEN_WR,
        RD_I, WT_I, RD_J, WT_J, WR_I, WR_J, RD_P, WT_P, WR_P
    } state_t;

    state_t     state_q;
    logic       rdy_q;
    logic [7:0] i_q, j_q, k_q, len_q, si_q, sj_q;
    logic [7:0] s_addr_q, s_wrdata_q, ct_addr_q, pt_addr_q, pt_wrdata_q;
    logic       s_wren_q, pt_wren_q;

    // 8-bit sums wrap modulo 256 by width alone.
    logic [7:0] j_d;
    logic [7:0] pad_idx;
    assign j_d     = j_q + s_rddata;
    assign pad_idx = si_q + sj_q;

    // Each action happens on the edge that enters the state named for it.
    // All outputs are registered, so reset clears them at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b1;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            len_q       <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            s_addr_q    <= '0;
            s_wrdata_q  <= '0;
            s_wren_q    <= 1'b0;
            ct_addr_q   <= '0;
            pt_addr_q   <= '0;
            pt_wrdata_q <= '0;
            pt_wren_q   <= 1'b0;
        end else begin
            // Write strobes are single-cycle pulses.
            s_wren_q  <= 1'b0;
            pt_wren_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en) begin
                        rdy_q     <= 1'b0;
                        i_q       <= '0;
                        j_q       <= '0;
                        k_q       <= '0;
                        ct_addr_q <= '0;
                        state_q   <= LEN_RD;
                    end
                end
                LEN_RD: state_q <= LEN_WT;
                LEN_WT: begin
                    len_q       <= ct_rddata;
                    pt_addr_q   <= '0;
                    pt_wrdata_q <= ct_rddata;
                    pt_wren_q   <= 1'b1;
                    k_q         <= 8'd1;
                    state_q     <= LEN_WR;
                end
                LEN_WR: begin
                    if (len_q == 8'd0) begin
                        rdy_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        i_q      <= 8'd1;
                        s_addr_q <= 8'd1;
                        state_q  <= RD_I;
                    end
                end
                RD_I: state_q <= WT_I;
                WT_I: begin
                    si_q     <= s_rddata;
                    j_q      <= j_d;
                    s_addr_q <= j_d;
                    state_q  <= RD_J;
                end
                RD_J: state_q <= WT_J;
                WT_J: begin
                    // Swap: S[i] <= sj first, then S[j] <= si. When i == j,
                    // both writes carry the same value and S[i] is unchanged.
                    sj_q       <= s_rddata;
                    s_addr_q   <= i_q;
                    s_wrdata_q <= s_rddata;
                    s_wren_q   <= 1'b1;
                    state_q    <= WR_I;
                end
                WR_I: begin
                    s_addr_q   <= j_q;
                    s_wrdata_q <= si_q;
                    s_wren_q   <= 1'b1;
                    state_q    <= WR_J;
                end
                WR_J: begin
                    // The pad index uses the values latched before the swap.
                    s_addr_q  <= pad_idx;
                    ct_addr_q <= k_q;
                    state_q   <= RD_P;
                end
                RD_P: state_q <= WT_P;
                WT_P: begin
                    pt_addr_q   <= k_q;
                    pt_wrdata_q <= s_rddata ^ ct_rddata;
                    pt_wren_q   <= 1'b1;
                    state_q     <= WR_P;
                end
                WR_P: begin
                    if (k_q == len_q) begin
                        rdy_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        k_q      <= k_q + 8'd1;
                        i_q      <= i_q + 8'd1;
                        s_addr_q <= i_q + 8'd1;
                        state_q  <= RD_I;
                    end
                end
                default: begin
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rdy       = rdy_q;
    assign s_addr    = s_addr_q;
    assign s_wrdata  = s_wrdata_q;
    assign s_wren    = s_wren_q;
    assign ct_addr   = ct_addr_q;
    assign pt_addr   = pt_addr_q;
    assign pt_wrdata = pt_wrdata_q;
    assign pt_wren   = pt_wren_q;

endmodule

// File: doc/prga.md
PRGA -- requirements
Module: prga

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port en, input, 1 bit: start request, sampled only while rdy=1.
REQ-004 SHALL have port rdy, output, 1 bit: idle and able to accept en.
REQ-005 SHALL have ports s_addr (output, 8 bits), s_rddata (input, 8 bits), s_wrdata (output, 8 bits) and s_wren (output, 1 bit): port to the 256x8 S memory already filled by key scheduling.
REQ-006 SHALL have ports ct_addr (output, 8 bits) and ct_rddata (input, 8 bits): read port to the ciphertext memory; ct[0] = length L, ct[1..L] = bytes.
REQ-007 SHALL have ports pt_addr (output, 8 bits), pt_wrdata (output, 8 bits) and pt_wren (output, 1 bit): write port to the plaintext memory; pt[0] = L, pt[1..L] = bytes.
REQ-008 SHALL treat every memory as synchronous read with one wait state: an address driven during cycle N gives data that is sampled at the end of cycle N+1.

Function
REQ-009 SHALL accept a start on the rising edge where rdy=1 and en=1; rdy SHALL be 0 from the next cycle until the operation completes.
REQ-010 SHALL ignore en while rdy=0, with no restart and no queuing.
REQ-011 SHALL clear i, j and k to 0 on accept; they SHALL NOT carry over from a previous run.
REQ-012 SHALL step the length phase through the states LEN_RD, LEN_WT and LEN_WR:
- LEN_RD: drive ct_addr=0.
- LEN_WT: hold ct_addr=0.
- LEN_WR: latch L, write pt[0]=L, set k=1.
REQ-013 SHALL go to IDLE after LEN_WR when L=0; otherwise it SHALL set i=1 and enter RD_I.
REQ-014 SHALL process each byte k in nine states, in this order:
- RD_I: s_addr=i.
- WT_I: hold.
- RD_J: latch si; j=(j+si) mod 256; s_addr=new j.
- WT_J: hold.
- WR_I: latch sj; write S[i]=sj.
- WR_J: write S[j]=si.
- RD_P: s_addr=(si+sj) mod 256; ct_addr=k.
- WT_P: hold.
- WR_P: pt_addr=k; pt_wrdata=s_rddata XOR ct_rddata; pt_wren=1.
REQ-015 SHALL, after WR_P, go to IDLE when k=L; otherwise k SHALL increment, i SHALL become (i+1) mod 256, and the FSM SHALL return to RD_I.
REQ-016 SHALL compute all i, j and pad-index arithmetic as 8-bit with modulo-256 wrap; no carry is kept.
REQ-017 SHALL, when i=j, perform both writes unchanged (same value twice), leaving S[i] unchanged.
REQ-018 SHALL latch si and sj as the pad-index operands before the swap; the pad index uses these latched values.
REQ-019 SHALL assert s_wren only in WR_I and WR_J, and pt_wren only in LEN_WR and WR_P, each for exactly one cycle; ct has no write.
REQ-020 SHALL assert rdy=1 again exactly 3+9L rising edges after the accepting edge, with L in 0..255.
REQ-021 SHALL allow a new en to be accepted on the first cycle that rdy=1 after completion.

Reset
REQ-022 SHALL, while rst=1, asynchronously force the FSM to IDLE with these output values:
- rdy=1
- s_wren=0, pt_wren=0
- s_addr, ct_addr, pt_addr, s_wrdata, pt_wrdata = 0
- i, j, k, L, si, sj = 0
REQ-023 SHALL, on rst assertion mid-operation, abort immediately with no further memory writes; memory contents already written SHALL be left as they are.
REQ-024 SHALL accept en on the first rising edge after rst deasserts.

Verification
REQ-025 Reset: assert rst mid-cycle -> rdy=1, s_wren=0 and pt_wren=0 immediately, before the next clk edge.
REQ-026 Empty message: ct[0]=0, en pulse -> pt[0]=0, no s_wren ever, rdy=1 three edges after accept.
REQ-027 Identity S (S[x]=x), ct={3,00,00,00} -> pt={03,02,05,07}; final S[2]=3, S[3]=5, S[5]=2, S[1]=1 (i=j case at k=1); rdy after 30 edges.
REQ-028 Same stimulus with ct={3,FF,0F,07} -> pt={03,FD,0A,00}.
REQ-029 en held high through the run, then rst pulsed during byte 2 -> rdy=1 and wrens=0 at once; a re-issued en restarts with i=j=0 and produces the REQ-027 result on a freshly reset S.
REQ-030 L=255 with random S and ct -> pt matches the golden software PRGA byte-for-byte, j wraps correctly, and rdy rises after 2298 edges.
